// File: rtl/branch_target_buffer_if.sv
// Lookup, tracking-pipe and update signals between the fetch/predictor side and the BTB.
// The master modport drives lookups and updates; the slave modport is the BTB itself.
interface branch_target_buffer_if #(
    parameter int unsigned PC_W = 32
);
    logic            pc_s1_valid_unused;
    logic [PC_W-1:0] pc_s1;
    logic            stall;
    logic            flush;
    logic            hit_s1;
    logic            p_s1;
    logic [PC_W-1:0] target_s1;
    logic            hit_s4;
    logic            p_s4;
    logic [PC_W-1:0] pc_s4;
    logic [PC_W-1:0] target_s4;
    logic            deviated_s4;
    logic            write_rp;
    logic            write_rt;

    modport master (
        output pc_s1, stall, flush, pc_s4, target_s4, deviated_s4, write_rp, write_rt,
        input  hit_s1, p_s1, target_s1, hit_s4, p_s4
    );

    modport slave (
        input  pc_s1, stall, flush, pc_s4, target_s4, deviated_s4, write_rp, write_rt,
        output hit_s1, p_s1, target_s1, hit_s4, p_s4
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters and a
// 3-deep tracking pipe that delivers each stage-1 lookup result to stage 4.
module branch_target_buffer #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IDX_W = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    branch_target_buffer_if.slave bus
);
    localparam int unsigned TAG_W   = PC_W - IDX_W - 2;
    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];
    logic [1:0]       cnt_d    [ENTRIES];

    // Tracking pipe: bit 0 is s2, bit 2 is s4.
    logic [2:0] pv_q, pv_d, ph_q, ph_d, pp_q, pp_d;

    logic [IDX_W-1:0] r_idx, w_idx;
    logic [TAG_W-1:0] r_tag, w_tag;
    logic             w_match;
    logic             unused_pc_lsbs;

    assign r_idx = bus.pc_s1[IDX_W+1:2];
    assign r_tag = bus.pc_s1[PC_W-1:IDX_W+2];
    assign w_idx = bus.pc_s4[IDX_W+1:2];
    assign w_tag = bus.pc_s4[PC_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{bus.pc_s1[1:0], bus.pc_s4[1:0]};

    assign bus.hit_s1    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign bus.p_s1      = bus.hit_s1 && cnt_q[r_idx][1];
    assign bus.target_s1 = bus.hit_s1 ? target_q[r_idx] : '0;
    assign bus.hit_s4    = pv_q[2] && ph_q[2];
    assign bus.p_s4      = pv_q[2] && pp_q[2];

    assign w_match = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (bus.write_rt) begin
            valid_d[w_idx]  = 1'b1;
            tag_d[w_idx]    = w_tag;
            target_d[w_idx] = bus.target_s4;
            cnt_d[w_idx]    = bus.deviated_s4 ? 2'b10 : 2'b01;
        end else if (bus.write_rp && w_match) begin
            if (bus.deviated_s4) begin
                if (cnt_q[w_idx] != 2'b11) cnt_d[w_idx] = cnt_q[w_idx] + 2'd1;
            end else begin
                if (cnt_q[w_idx] != 2'b00) cnt_d[w_idx] = cnt_q[w_idx] - 2'd1;
            end
        end
    end

    always_comb begin
        pv_d = pv_q;
        ph_d = ph_q;
        pp_d = pp_q;
        if (bus.flush) begin
            pv_d = '0;
            ph_d = '0;
            pp_d = '0;
        end else if (!bus.stall) begin
            pv_d = {pv_q[1:0], 1'b1};
            ph_d = {ph_q[1:0], bus.hit_s1};
            pp_d = {pp_q[1:0], bus.p_s1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
            pv_q <= '0;
            ph_q <= '0;
            pp_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            pv_q     <= pv_d;
            ph_q     <= ph_d;
            pp_q     <= pp_d;
        end
    end
endmodule
